// File: rtl/flash_spi_engine.sv
// rtl/flash_spi_engine.sv - byte-level single-bit SPI command engine for the configuration flash
// Instruction, queued write bytes, then response bytes; mode 0, MSB first.

module flash_spi_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    q,
  output logic [AW:0]   level
);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        full;
  logic        empty;

  assign level = wr_ptr - rd_ptr;
  assign full  = (level == FULL_LVL);
  assign empty = (level == '0);
  assign q     = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

module flash_spi_engine #(
  parameter int CLK_DIV      = 2,
  parameter int DESEL_CYCLES = 4,
  parameter int WR_DEPTH     = 512,
  parameter int RD_DEPTH     = 256
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] instruction,
  input  logic       execute,
  input  logic [8:0] bytes_to_read,
  output logic       busy,
  input  logic [7:0] write_buffer_data,
  input  logic       write_buffer_write,
  output logic       write_buffer_full,
  output logic [7:0] read_buffer_q,
  output logic       read_buffer_empty,
  input  logic       read_buffer_read,
  output logic       flash_c,
  output logic       flash_sb,
  inout  wire  [3:0] flash_dq
);
  localparam int WA = $clog2(WR_DEPTH);
  localparam int RA = $clog2(RD_DEPTH);
  localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
  localparam logic [15:0] DESEL_LAST = 16'(DESEL_CYCLES - 1);
  localparam logic [WA:0] WR_FULL    = WR_DEPTH[WA:0];
  localparam logic [RA:0] RD_FULL    = RD_DEPTH[RA:0];

  typedef enum logic [2:0] {
    IDLE, CS_SETUP, SHIFT_INSTR, SHIFT_WRITE, SHIFT_READ, CS_HOLD, DESELECT
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] cnt;
  logic        sck;
  logic [2:0]  bit_cnt;
  logic [7:0]  sh;
  logic [7:0]  rx;
  logic [WA:0] wr_left;
  logic [8:0]  rd_left;
  logic        mosi;

  logic [7:0]  wr_q;
  logic [WA:0] wr_level;
  logic [RA:0] rd_level;
  logic        rd_full;
  logic        wr_push_ok;
  logic        accept;
  logic        shifting;
  logic        tick;
  logic        stall;
  logic        bit_rise;
  logic        bit_fall;
  logic        byte_done;
  logic        wr_pop;
  logic        rd_push;
  logic        miso;
  logic [8:0]  rd_len;

  assign write_buffer_full = (wr_level == WR_FULL);
  assign rd_full           = (rd_level == RD_FULL);
  assign read_buffer_empty = (rd_level == '0);
  assign wr_push_ok        = write_buffer_write && !write_buffer_full;
  assign miso              = flash_dq[1];
  assign flash_dq          = {2'b11, 1'bz, mosi};
  assign flash_c           = sck;
  assign rd_len            = (bytes_to_read > 9'd256) ? 9'd256 : bytes_to_read;

  assign accept    = (state == IDLE) && execute;
  assign shifting  = (state == SHIFT_INSTR) || (state == SHIFT_WRITE) || (state == SHIFT_READ);
  assign tick      = (cnt == DIV_LAST);
  // A read byte may only start once the read FIFO can take it.
  assign stall     = (state == SHIFT_READ) && !sck && (bit_cnt == 3'd0) && rd_full;
  assign bit_rise  = shifting && !sck && tick && !stall;
  assign bit_fall  = shifting && sck && tick;
  assign byte_done = bit_fall && (bit_cnt == 3'd7);
  assign wr_pop    = byte_done && ((state == SHIFT_INSTR) || (state == SHIFT_WRITE)) && (wr_left != '0);
  assign rd_push   = byte_done && (state == SHIFT_READ);

  flash_spi_fifo #(.DEPTH(WR_DEPTH)) u_wr_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (write_buffer_write),
    .push_data (write_buffer_data),
    .pop       (wr_pop),
    .q         (wr_q),
    .level     (wr_level)
  );

  flash_spi_fifo #(.DEPTH(RD_DEPTH)) u_rd_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (rd_push),
    .push_data (rx),
    .pop       (read_buffer_read),
    .q         (read_buffer_q),
    .level     (rd_level)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:        if (execute) state_next = CS_SETUP;
      CS_SETUP:    if (tick) state_next = SHIFT_INSTR;
      SHIFT_INSTR: if (byte_done)
                     state_next = (wr_left != '0) ? SHIFT_WRITE :
                                  (rd_left != '0) ? SHIFT_READ : CS_HOLD;
      SHIFT_WRITE: if (byte_done && (wr_left == '0))
                     state_next = (rd_left != '0) ? SHIFT_READ : CS_HOLD;
      SHIFT_READ:  if (byte_done && (rd_left == 9'd1)) state_next = CS_HOLD;
      CS_HOLD:     if (tick) state_next = DESELECT;
      DESELECT:    if (cnt == DESEL_LAST) state_next = IDLE;
      default:     state_next = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    flash_sb = (state == IDLE) || (state == DESELECT);
    mosi     = ((state == SHIFT_INSTR) || (state == SHIFT_WRITE)) ? sh[7] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt     <= '0;
      sck     <= 1'b0;
      bit_cnt <= '0;
      sh      <= '0;
      rx      <= '0;
      wr_left <= '0;
      rd_left <= '0;
    end else begin
      if ((state != state_next) || (state == IDLE)) cnt <= '0;
      else if (shifting) cnt <= (stall) ? cnt : (tick ? '0 : cnt + 16'd1);
      else cnt <= cnt + 16'd1;

      if (bit_rise) begin
        sck <= 1'b1;
        rx  <= {rx[6:0], miso};
      end
      if (bit_fall) begin
        sck     <= 1'b0;
        bit_cnt <= bit_cnt + 3'd1;
        sh      <= wr_pop ? wr_q : {sh[6:0], 1'b0};
      end

      // Occupancy snapshot includes a push landing on the accepting edge.
      if (accept) begin
        sh      <= instruction;
        wr_left <= wr_level + {{WA{1'b0}}, wr_push_ok};
        rd_left <= rd_len;
      end else begin
        if (wr_pop)  wr_left <= wr_left - 1'b1;
        if (rd_push) rd_left <= rd_left - 9'd1;
      end
    end
  end
endmodule

// File: tb/tb_flash_spi_engine.sv
// tb/tb_flash_spi_engine.sv - directed self-checking bench for flash_spi_engine
// Flash model serves response bits on dq[1] and captures MOSI on rising c.

module tb_flash_spi_engine;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] instruction = 8'h00;
  logic       execute = 1'b0;
  logic [8:0] bytes_to_read = 9'd0;
  logic       busy;
  logic [7:0] write_buffer_data = 8'h00;
  logic       write_buffer_write = 1'b0;
  logic       write_buffer_full;
  logic [7:0] read_buffer_q;
  logic       read_buffer_empty;
  logic       read_buffer_read = 1'b0;
  logic       flash_c;
  logic       flash_sb;
  wire  [3:0] dq;

  int tests = 0;
  int fails = 0;

  logic       miso;
  int         pre_bits = 0;
  logic [7:0] resp [8];
  int         mk;
  int         pulse_cnt = 0;
  int         busy_cyc = 0;
  int         sb_err = 0;
  logic [7:0] mosi_b [16];
  logic       sb_prev = 1'b1;
  logic       c_prev = 1'b0;

  always #5 clk = ~clk;

  assign dq[1] = miso;

  flash_spi_engine #(
    .CLK_DIV(2), .DESEL_CYCLES(4), .WR_DEPTH(512), .RD_DEPTH(4)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .instruction        (instruction),
    .execute            (execute),
    .bytes_to_read      (bytes_to_read),
    .busy               (busy),
    .write_buffer_data  (write_buffer_data),
    .write_buffer_write (write_buffer_write),
    .write_buffer_full  (write_buffer_full),
    .read_buffer_q      (read_buffer_q),
    .read_buffer_empty  (read_buffer_empty),
    .read_buffer_read   (read_buffer_read),
    .flash_c            (flash_c),
    .flash_sb           (flash_sb),
    .flash_dq           (dq)
  );

  always_comb begin
    mk = pulse_cnt - pre_bits;
    if (mk >= 0 && mk < 64) miso = resp[mk / 8][7 - (mk % 8)];
    else                    miso = 1'b0;
  end

  always @(negedge clk) begin
    if (sb_prev && !flash_sb) begin
      pulse_cnt = 0;
      sb_err    = 0;
      busy_cyc  = 1;
      for (int i = 0; i < 16; i++) mosi_b[i] = 8'h00;
    end else if (busy) begin
      busy_cyc++;
    end
    if (!c_prev && flash_c) begin
      if (pulse_cnt < 128) mosi_b[pulse_cnt / 8] = {mosi_b[pulse_cnt / 8][6:0], dq[0]};
      if (flash_sb) sb_err++;
      pulse_cnt++;
    end
    sb_prev = flash_sb;
    c_prev  = flash_c;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input logic [7:0] op, input logic [8:0] n);
    @(negedge clk);
    instruction   = op;
    bytes_to_read = n;
    execute       = 1'b1;
    @(negedge clk);
    execute = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while (busy && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    write_buffer_data  = b;
    write_buffer_write = 1'b1;
    @(negedge clk);
    write_buffer_write = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    @(negedge clk);
    check(tag, {24'd0, read_buffer_q}, {24'd0, exp});
    read_buffer_read = 1'b1;
    @(negedge clk);
    read_buffer_read = 1'b0;
  endtask

  task automatic wait_pulses(input string tag, input int n);
    int t = 0;
    while (pulse_cnt < n && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check(tag, {31'd0, (pulse_cnt >= n)}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) resp[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_sb", {31'd0, flash_sb}, 32'd1);
    check("rst_c", {31'd0, flash_c}, 32'd0);
    check("rst_dq0", {31'd0, dq[0]}, 32'd0);
    check("rst_rd_empty", {31'd0, read_buffer_empty}, 32'd1);
    check("rst_wr_full", {31'd0, write_buffer_full}, 32'd0);
    reset_n = 1'b1;

    // WREN
    run_cmd(8'h06, 9'd0);
    wait_idle("wren_idle");
    check("wren_pulses", pulse_cnt, 32'd8);
    check("wren_mosi", {24'd0, mosi_b[0]}, 32'h06);
    check("wren_sb", sb_err, 32'd0);
    check("wren_busy", busy_cyc, 32'd40);
    check("wren_rd_empty", {31'd0, read_buffer_empty}, 32'd1);

    // RFSR
    resp[0] = 8'h80;
    pre_bits = 8;
    run_cmd(8'h70, 9'd1);
    wait_idle("rfsr_idle");
    check("rfsr_pulses", pulse_cnt, 32'd16);
    check("rfsr_busy", busy_cyc, 32'd72);
    check("rfsr_not_empty", {31'd0, read_buffer_empty}, 32'd0);
    pop_check("rfsr_q", 8'h80);
    check("rfsr_empty", {31'd0, read_buffer_empty}, 32'd1);

    // Page program
    push_byte(8'h00); push_byte(8'h01); push_byte(8'h00); push_byte(8'hDE);
    push_byte(8'hAD); push_byte(8'hBE); push_byte(8'hEF);
    run_cmd(8'h02, 9'd0);
    wait_idle("pp_idle");
    check("pp_pulses", pulse_cnt, 32'd64);
    check("pp_b0", {24'd0, mosi_b[0]}, 32'h02);
    check("pp_b1", {24'd0, mosi_b[1]}, 32'h00);
    check("pp_b2", {24'd0, mosi_b[2]}, 32'h01);
    check("pp_b3", {24'd0, mosi_b[3]}, 32'h00);
    check("pp_b4", {24'd0, mosi_b[4]}, 32'hDE);
    check("pp_b5", {24'd0, mosi_b[5]}, 32'hAD);
    check("pp_b6", {24'd0, mosi_b[6]}, 32'hBE);
    check("pp_b7", {24'd0, mosi_b[7]}, 32'hEF);
    check("pp_sb", sb_err, 32'd0);

    // Queue isolation: push and re-execute during a command
    run_cmd(8'h06, 9'd0);
    @(negedge clk);
    write_buffer_data  = 8'h55;
    write_buffer_write = 1'b1;
    instruction        = 8'hFF;
    execute            = 1'b1;
    @(negedge clk);
    write_buffer_write = 1'b0;
    execute            = 1'b0;
    wait_idle("qi_idle");
    check("qi_pulses", pulse_cnt, 32'd8);
    check("qi_mosi", {24'd0, mosi_b[0]}, 32'h06);
    repeat (5) @(negedge clk);
    check("qi_no_restart", {31'd0, busy}, 32'd0);
    run_cmd(8'h9F, 9'd0);
    wait_idle("qi2_idle");
    check("qi2_pulses", pulse_cnt, 32'd16);
    check("qi2_b0", {24'd0, mosi_b[0]}, 32'h9F);
    check("qi2_b1", {24'd0, mosi_b[1]}, 32'h55);

    // Read stall with a 4-deep read FIFO
    resp[0] = 8'h11; resp[1] = 8'h22; resp[2] = 8'h33;
    resp[3] = 8'h44; resp[4] = 8'h55; resp[5] = 8'h66;
    pre_bits = 8;
    run_cmd(8'h03, 9'd6);
    wait_pulses("st_reach", 40);
    repeat (40) @(negedge clk);
    check("st_halt_pulses", pulse_cnt, 32'd40);
    check("st_halt_c", {31'd0, flash_c}, 32'd0);
    check("st_halt_busy", {31'd0, busy}, 32'd1);
    pop_check("st_q0", 8'h11);
    pop_check("st_q1", 8'h22);
    wait_idle("st_idle");
    check("st_pulses", pulse_cnt, 32'd56);
    pop_check("st_q2", 8'h33);
    pop_check("st_q3", 8'h44);
    pop_check("st_q4", 8'h55);
    pop_check("st_q5", 8'h66);
    check("st_empty", {31'd0, read_buffer_empty}, 32'd1);

    // Reset mid-op, with a byte left in the read FIFO
    resp[0] = 8'h80;
    run_cmd(8'h70, 9'd1);
    wait_idle("ro_pre_idle");
    check("ro_pre_rd", {31'd0, read_buffer_empty}, 32'd0);
    push_byte(8'hAA); push_byte(8'hBB); push_byte(8'hCC); push_byte(8'hDD);
    run_cmd(8'h02, 9'd0);
    wait_pulses("ro_reach", 19);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("ro_sb", {31'd0, flash_sb}, 32'd1);
    check("ro_c", {31'd0, flash_c}, 32'd0);
    check("ro_busy", {31'd0, busy}, 32'd0);
    check("ro_rd_empty", {31'd0, read_buffer_empty}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    run_cmd(8'h06, 9'd0);
    wait_idle("ro_wren_idle");
    check("ro_wren_pulses", pulse_cnt, 32'd8);
    check("ro_wren_mosi", {24'd0, mosi_b[0]}, 32'h06);
    check("ro_wren_busy", busy_cyc, 32'd40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
